// File: rtl/seq_gen_if.sv
// rtl/seq_gen_if.sv - request (start/count/abort) and serial output bundle for seq_gen
// Signal prefixes follow the generator's point of view: i_ driven by the requester, o_ by seq_gen.
interface seq_gen_if #(
  parameter int CNT_W = 4
);
  logic             i_start;
  logic [CNT_W-1:0] i_count;
  logic             i_abort;
  logic             o_out;
  logic             o_out_valid;
  logic             o_busy;
  logic             o_done;

  modport master (output i_start, i_count, i_abort,
                  input  o_out, o_out_valid, o_busy, o_done);
  modport slave  (input  i_start, i_count, i_abort,
                  output o_out, o_out_valid, o_busy, o_done);
endinterface

// File: rtl/seq_gen.sv
// rtl/seq_gen.sv - repeating MSB-first serial pattern generator with repetition count and abort
// Optional macro SEQ_GEN_GAP_EN inserts GAP_LEN idle cycles between repetitions.
module seq_gen #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
  parameter int                 CNT_W   = 4,
  parameter int                 GAP_LEN = 2
) (
  input  logic     clk,
  input  logic     rst,
  seq_gen_if.slave bus
);

`ifdef SEQ_GEN_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2, DONE = 2'd3} state_t;
  localparam logic [3:0] GAP_LAST = 4'(GAP_LEN - 1);
  logic [3:0] r_gap_cnt, w_gap_cnt_nxt;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd3} state_t;
`endif

  localparam logic [2:0] BIT_LAST = 3'(PAT_LEN - 1);

  state_t             r_state, w_state_nxt;
  logic [PAT_LEN-1:0] r_shift, w_shift_nxt;
  logic [2:0]         r_bit_cnt, w_bit_cnt_nxt;
  logic [CNT_W-1:0]   r_rep_cnt, w_rep_cnt_nxt;
  logic               r_out, r_out_valid, r_busy, r_done;
  logic               w_in_shift, w_in_busy;

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_rep_cnt_nxt = r_rep_cnt;
`ifdef SEQ_GEN_GAP_EN
    w_gap_cnt_nxt = r_gap_cnt;
`endif
    unique case (r_state)
      IDLE: begin
        if (bus.i_start && !bus.i_abort) begin
          w_rep_cnt_nxt = bus.i_count;
          w_shift_nxt   = PATTERN;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = (bus.i_count == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (bus.i_abort) begin
          w_state_nxt = IDLE;
        end else if (r_bit_cnt == BIT_LAST) begin
          // Last bit of a repetition: count it off and either finish or start over.
          w_rep_cnt_nxt = r_rep_cnt - CNT_W'(1);
          w_bit_cnt_nxt = '0;
          w_shift_nxt   = PATTERN;
          if (r_rep_cnt == CNT_W'(1)) begin
            w_state_nxt = DONE;
          end else begin
`ifdef SEQ_GEN_GAP_EN
            w_gap_cnt_nxt = '0;
            w_state_nxt   = GAP;
`else
            w_state_nxt   = SHIFT;
`endif
          end
        end else begin
          w_shift_nxt   = {r_shift[PAT_LEN-2:0], 1'b0};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        end
      end
`ifdef SEQ_GEN_GAP_EN
      GAP: begin
        if (bus.i_abort) begin
          w_state_nxt = IDLE;
        end else if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = SHIFT;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 4'd1;
        end
      end
`endif
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  assign w_in_shift = (w_state_nxt == SHIFT);
`ifdef SEQ_GEN_GAP_EN
  assign w_in_busy  = w_in_shift || (w_state_nxt == GAP);
`else
  assign w_in_busy  = w_in_shift;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_shift     <= PATTERN;
      r_bit_cnt   <= '0;
      r_rep_cnt   <= '0;
`ifdef SEQ_GEN_GAP_EN
      r_gap_cnt   <= '0;
`endif
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_rep_cnt   <= w_rep_cnt_nxt;
`ifdef SEQ_GEN_GAP_EN
      r_gap_cnt   <= w_gap_cnt_nxt;
`endif
      r_out       <= w_in_shift && w_shift_nxt[PAT_LEN-1];
      r_out_valid <= w_in_shift;
      r_busy      <= w_in_busy;
      r_done      <= (w_state_nxt == DONE);
    end
  end

  assign bus.o_out       = r_out;
  assign bus.o_out_valid = r_out_valid;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;

endmodule

// File: tb/tb_seq_gen.sv
// tb/tb_seq_gen.sv - directed and randomized checks of seq_gen against a cycle trace model
// Model builds the expected {out,out_valid,busy,done} trace per transaction from the repetition rules.
`timescale 1ns/1ps
module tb_seq_gen;
  localparam int            PL  = 4;
  localparam logic [PL-1:0] PAT = 4'b1001;
  localparam int            CW  = 4;
  localparam int            GL  = 2;
`ifdef SEQ_GEN_GAP_EN
  localparam int GAPS = GL;
`else
  localparam int GAPS = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_gen_if #(.CNT_W(CW)) bus ();

  seq_gen #(.PAT_LEN(PL), .PATTERN(PAT), .CNT_W(CW), .GAP_LEN(GL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [3:0] exp);
    logic [3:0] o;
    o = {bus.o_out, bus.o_out_valid, bus.o_busy, bus.o_done};
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s: observed {out,valid,busy,done}=%b expected %b", tag, o, exp);
    end
  endtask

  // One entry per cycle after start is sampled; ends with an idle cycle.
  task automatic build_exp(input int c, input int abort_k);
    exp_q.delete();
    for (int r = 0; r < c; r++) begin
      for (int b = 0; b < PL; b++) exp_q.push_back({PAT[PL-1-b], 1'b1, 1'b1, 1'b0});
      if (r < c - 1)
        for (int g = 0; g < GAPS; g++) exp_q.push_back(4'b0010);
    end
    if (abort_k >= 0) begin
      while (exp_q.size() > abort_k + 1) void'(exp_q.pop_back());
      exp_q.push_back(4'b0000);
    end else begin
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0000);
    end
  endtask

  // Called just after a negedge; noise holds start high and scrambles count while busy/done.
  task automatic run_txn(input int c, input int abort_k, input bit noise, input string tag);
    build_exp(c, abort_k);
    bus.i_start = 1'b1;
    bus.i_count = CW'(c);
    bus.i_abort = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, i), exp_q[i]);
      bus.i_abort = (i == abort_k);
      bus.i_start = noise && (i < exp_q.size() - 1);
      bus.i_count = noise ? CW'($urandom) : CW'(c);
    end
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
  endtask

  initial begin
    int c;
    int ak;
    int blen;
    bus.i_start = 1'b0;
    bus.i_count = '0;
    bus.i_abort = 1'b0;

    #1 rst = 1'b0;
    #1 check("reset_async", 4'b0000);
    repeat (2) @(negedge clk);
    check("reset_hold", 4'b0000);
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 4'b0000);

    run_txn(2, -1, 1'b0, "cnt2");
    run_txn(0, -1, 1'b0, "cnt0");
    run_txn(3, 5 + GAPS, 1'b0, "abort_rep2_bit2");
    run_txn(1, -1, 1'b0, "start_after_abort");
    run_txn(15, -1, 1'b1, "cnt_max_noise");
    run_txn(2, -1, 1'b1, "cnt2_noise");

    bus.i_start = 1'b1;
    bus.i_abort = 1'b1;
    bus.i_count = 4'd3;
    repeat (3) begin
      @(negedge clk);
      check("abort_beats_start", 4'b0000);
    end
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;

    bus.i_start = 1'b1;
    bus.i_count = 4'd2;
    @(negedge clk);
    bus.i_start = 1'b0;
    check("pre_reset_shift", {PAT[PL-1], 3'b110});
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("reset_mid_shift", 4'b0000);
    @(negedge clk);
    check("reset_mid_held", 4'b0000);
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_rereset", 4'b0000);
    run_txn(1, -1, 1'b0, "after_rereset");

    for (int t = 0; t < 25; t++) begin
      c    = $urandom_range(0, 15);
      blen = (c > 0) ? c * PL + (c - 1) * GAPS : 0;
      ak   = (c > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, blen - 1) : -1;
      run_txn(c, ak, 1'($urandom_range(0, 1)), $sformatf("rand%0d_c%0d_a%0d", t, c, ak));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
